instr_loader: RTL



---
 rtl/riscv_pkg.sv | 13 +
 rtl/instr_word_assembler.sv | 35 +++
 rtl/instr_loader.sv | 110 +++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: opcode constants shared with the decoder and the instruction-loader state enum.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_OP   = 7'b0110011;

    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, DONE, ERROR} ld_state_e;

    function automatic logic opc_supported(input logic [6:0] opc);
        return (opc == OPC_LOAD) || (opc == OPC_OP);
    endfunction

endpackage

// File: rtl/instr_word_assembler.sv
// instr_word_assembler: packs four bytes little-endian into a 32-bit word.
// A partial word is held across input gaps until clr_i or reset.
module instr_word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_done_o
);

    logic [1:0]  idx_q, idx_d;
    logic [23:0] sr_q, sr_d;

    // The 4th byte goes straight into the top lane, so the word is ready on its accept edge.
    always_comb begin
        idx_d = clr_i ? 2'd0 : en_i ? idx_q + 2'd1 : idx_q;
        sr_d  = clr_i ? 24'd0 : en_i ? {byte_i, sr_q[23:8]} : sr_q;
    end

    assign word_o      = {byte_i, sr_q};
    assign word_done_o = en_i && (idx_q == 2'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= 2'd0;
            sr_q  <= 24'd0;
        end else begin
            idx_q <= idx_d;
            sr_q  <= sr_d;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// instr_loader: length-prefixed byte stream to sequential instruction-memory writes.
// Optional macro INSTR_LOADER_OPCODE_CHECK_EN flags words with unsupported opcodes.
module instr_loader
    import riscv_pkg::*;
#(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_WE,
    output logic [ADDR_WIDTH-1:0] imem_WA,
    output logic [31:0]           imem_WD,
    output logic                  core_hold,
    output logic                  done,
    output logic                  error,
    output logic                  err_opcode
);

    ld_state_e             state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [ADDR_WIDTH:0]   wcnt_q, wcnt_d;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] wa_q;
    logic [31:0]           wd_q;
    logic                  accept, hon_start, word_done, all_written;
    logic [31:0]           word;
    logic [15:0]           len;

    assign all_written = (16'(wcnt_q) == cnt_q);
    // in_ready drops during the final write cycle, before the state leaves DATA.
    assign in_ready    = (state_q == LEN0) || (state_q == LEN1) || ((state_q == DATA) && !all_written);
    assign accept      = in_valid && in_ready;
    assign hon_start   = start && ((state_q == IDLE) || (state_q == ERROR));
    assign len         = {in_data, cnt_q[7:0]};
    assign core_hold   = (state_q == LEN0) || (state_q == LEN1) || (state_q == DATA) || (state_q == ERROR);
    assign done        = (state_q == DONE);
    assign error       = (state_q == ERROR);
    assign imem_WE     = we_q;
    assign imem_WA     = wa_q;
    assign imem_WD     = wd_q;

    instr_word_assembler u_asm (
        .clk         (clk),
        .reset       (reset),
        .clr_i       (hon_start),
        .en_i        (accept && (state_q == DATA)),
        .byte_i      (in_data),
        .word_o      (word),
        .word_done_o (word_done)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wcnt_d  = hon_start ? '0 : word_done ? wcnt_q + 1'b1 : wcnt_q;
        case (state_q)
            IDLE, ERROR: state_d = start ? LEN0 : state_q;
            LEN0: begin
                cnt_d[7:0] = accept ? in_data : cnt_q[7:0];
                state_d    = accept ? LEN1 : LEN0;
            end
            LEN1: begin
                cnt_d[15:8] = accept ? in_data : cnt_q[15:8];
                state_d     = !accept ? LEN1 : (len == 16'd0) ? DONE :
                              (32'(len) > (32'd1 << ADDR_WIDTH)) ? ERROR : DATA;
            end
            DATA:    state_d = all_written ? DONE : DATA;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            wcnt_q  <= '0;
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            we_q    <= word_done;
            wa_q    <= word_done ? wcnt_q[ADDR_WIDTH-1:0] : wa_q;
            wd_q    <= word_done ? word : wd_q;
        end
    end

`ifdef INSTR_LOADER_OPCODE_CHECK_EN
    logic err_opc_q;

    always_ff @(posedge clk) begin
        if (reset || hon_start)
            err_opc_q <= 1'b0;
        else if (word_done && !opc_supported(word[6:0]))
            err_opc_q <= 1'b1;
    end

    assign err_opcode = err_opc_q;
`else
    assign err_opcode = 1'b0;
`endif

endmodule
